// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the RegisterFile write port between ALU and load
// writeback, with a per-register pending-write scoreboard for decode hazards.
module rf_write_arbiter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_reg,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_reg,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    input  logic                claim_valid,
    input  logic [ADDR_W-1:0]   claim_reg,
    input  logic [ADDR_W-1:0]   rd_reg1,
    input  logic [ADDR_W-1:0]   rd_reg2,
    output logic                rd_busy1,
    output logic                rd_busy2,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                rf_WriteReg,
    output logic [ADDR_W-1:0]   rf_DstReg,
    output logic [DATA_W-1:0]   rf_DstData
);

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } state_t;

    state_t              r_state;
    logic                w_gnt0;
    logic                w_gnt1;
    logic [ADDR_W-1:0]   w_win_reg;
    logic [DATA_W-1:0]   w_win_data;
    logic                w_win_zero;
    logic                w_claim_ok;
    logic [NUM_REGS-1:0] w_busy_next;

    // Grant logic: tie broken by the pointer, lone requester always wins.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst) begin
            w_gnt0 = req0_valid && (!req1_valid || (r_state == PRI0));
            w_gnt1 = req1_valid && (!req0_valid || (r_state == PRI1));
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        w_win_reg  = req0_reg;
        w_win_data = req0_data;
        if (w_gnt1) begin
            w_win_reg  = req1_reg;
            w_win_data = req1_data;
        end
    end

    // Register 0 writes are accepted but never reach the RegisterFile.
    assign w_win_zero = (ZERO_REG != 0) && (w_win_reg == '0);
    assign w_claim_ok = claim_valid && !((ZERO_REG != 0) && (claim_reg == '0));

    // Clear on RF commit first so a same-edge claim of that register wins.
    always_comb begin
        w_busy_next = busy_vec;
        if (rf_WriteReg) begin
            w_busy_next[rf_DstReg] = 1'b0;
        end
        if (w_claim_ok) begin
            w_busy_next[claim_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= PRI0;
            rf_WriteReg <= 1'b0;
            rf_DstReg   <= '0;
            rf_DstData  <= '0;
            busy_vec    <= '0;
        end else begin
            busy_vec <= w_busy_next;
            if (w_gnt0) begin
                r_state <= PRI1;
            end else if (w_gnt1) begin
                r_state <= PRI0;
            end
            if (w_gnt0 || w_gnt1) begin
                rf_WriteReg <= !w_win_zero;
                rf_DstReg   <= w_win_reg;
                rf_DstData  <= w_win_data;
            end else begin
                rf_WriteReg <= 1'b0;
            end
        end
    end

    assign rd_busy1 = rst && busy_vec[rd_reg1];
    assign rd_busy2 = rst && busy_vec[rd_reg2];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: arbitration, write stage, scoreboard, reset.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [3:0]  req0_reg;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [3:0]  req1_reg;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        claim_valid;
    logic [3:0]  claim_reg;
    logic [3:0]  rd_reg1;
    logic [3:0]  rd_reg2;
    logic        rd_busy1;
    logic        rd_busy2;
    logic [15:0] busy_vec;
    logic        rf_WriteReg;
    logic [3:0]  rf_DstReg;
    logic [15:0] rf_DstData;

    int n_checks;
    int n_fail;

    rf_write_arbiter #(
        .DATA_W  (16),
        .ADDR_W  (4),
        .NUM_REGS(16),
        .ZERO_REG(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_reg   (req0_reg),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_reg   (req1_reg),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .claim_valid(claim_valid),
        .claim_reg  (claim_reg),
        .rd_reg1    (rd_reg1),
        .rd_reg2    (rd_reg2),
        .rd_busy1   (rd_busy1),
        .rd_busy2   (rd_busy2),
        .busy_vec   (busy_vec),
        .rf_WriteReg(rf_WriteReg),
        .rf_DstReg  (rf_DstReg),
        .rf_DstData (rf_DstData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_valid = 1'b1; req0_reg = 4'h1; req0_data = 16'h1111;
        req1_valid = 1'b1; req1_reg = 4'h2; req1_data = 16'h2222;
        #1;
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b%b exp 00", req0_ready, req1_ready);
        end
        step();
        step();
        n_checks++;
        if (rf_WriteReg !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr: got %b exp 0", rf_WriteReg);
        end
        n_checks++;
        if (busy_vec !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_busy: got %h exp 0000", busy_vec);
        end
        n_checks++;
        if (rf_DstReg !== 4'h0 || rf_DstData !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_dst: got %h/%h exp 0/0000", rf_DstReg, rf_DstData);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pri0: got %b%b exp 10", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_lone();
        req0_valid = 1'b1; req0_reg = 4'h1; req0_data = 16'h0001;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_ready: got %b%b exp 10", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        n_checks++;
        if (rf_WriteReg !== 1'b1 || rf_DstReg !== 4'h1 || rf_DstData !== 16'h0001) begin
            n_fail++;
            $display("FAIL lone_write: got %b/%h/%h exp 1/1/0001", rf_WriteReg, rf_DstReg, rf_DstData);
        end
        step();
        n_checks++;
        if (rf_WriteReg !== 1'b0 || rf_DstReg !== 4'h1 || rf_DstData !== 16'h0001) begin
            n_fail++;
            $display("FAIL lone_idle: got %b/%h/%h exp 0/1/0001", rf_WriteReg, rf_DstReg, rf_DstData);
        end
    endtask

    task automatic test_tie();
        logic [3:0]  exp_reg;
        logic [15:0] exp_data;
        rst = 1'b0;
        step();
        rst = 1'b1;
        req0_valid = 1'b1; req0_reg = 4'h2; req0_data = 16'hAAAA;
        req1_valid = 1'b1; req1_reg = 4'h3; req1_data = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (req0_ready !== ((i % 2) == 0) || req1_ready !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL tie_grant%0d: got %b%b exp %b%b", i, req0_ready, req1_ready,
                         (i % 2) == 0, (i % 2) == 1);
            end
            step();
            exp_reg  = ((i % 2) == 0) ? 4'h2 : 4'h3;
            exp_data = ((i % 2) == 0) ? 16'hAAAA : 16'h5555;
            n_checks++;
            if (rf_WriteReg !== 1'b1 || rf_DstReg !== exp_reg || rf_DstData !== exp_data) begin
                n_fail++;
                $display("FAIL tie_write%0d: got %b/%h/%h exp 1/%h/%h", i, rf_WriteReg,
                         rf_DstReg, rf_DstData, exp_reg, exp_data);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        req0_valid = 1'b1; req0_reg = 4'hA; req0_data = 16'h00AA;
        step();
        req0_reg = 4'hB; req0_data = 16'h00BB;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b exp 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        n_checks++;
        if (rf_WriteReg !== 1'b1 || rf_DstReg !== 4'hB || rf_DstData !== 16'h00BB) begin
            n_fail++;
            $display("FAIL b2b_write: got %b/%h/%h exp 1/b/00bb", rf_WriteReg, rf_DstReg, rf_DstData);
        end
        step();
    endtask

    task automatic test_scoreboard();
        claim_valid = 1'b1; claim_reg = 4'h5;
        rd_reg1 = 4'h5; rd_reg2 = 4'h6;
        step();
        claim_valid = 1'b0;
        #1;
        n_checks++;
        if (busy_vec !== 16'h0020 || rd_busy1 !== 1'b1 || rd_busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_claim: got %h/%b/%b exp 0020/1/0", busy_vec, rd_busy1, rd_busy2);
        end
        req1_valid = 1'b1; req1_reg = 4'h5; req1_data = 16'h1234;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_req1_ready: got %b exp 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        n_checks++;
        if (busy_vec !== 16'h0020 || rf_WriteReg !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_pre_commit: got %h/%b exp 0020/1", busy_vec, rf_WriteReg);
        end
        step();
        n_checks++;
        if (busy_vec !== 16'h0000 || rd_busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_clear: got %h/%b exp 0000/0", busy_vec, rd_busy1);
        end
        // Same-edge claim and clear of reg 5.
        claim_valid = 1'b1; claim_reg = 4'h5;
        step();
        claim_valid = 1'b0;
        req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        claim_valid = 1'b1; claim_reg = 4'h5;
        step();
        claim_valid = 1'b0;
        n_checks++;
        if (busy_vec !== 16'h0020) begin
            n_fail++;
            $display("FAIL sb_set_wins: got %h exp 0020", busy_vec);
        end
        // Clear reg 5 and claim reg 7 on the same edge.
        req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        claim_valid = 1'b1; claim_reg = 4'h7;
        step();
        claim_valid = 1'b0;
        n_checks++;
        if (busy_vec !== 16'h0080) begin
            n_fail++;
            $display("FAIL sb_both: got %h exp 0080", busy_vec);
        end
    endtask

    task automatic test_r0();
        claim_valid = 1'b1; claim_reg = 4'h0;
        step();
        claim_valid = 1'b0;
        n_checks++;
        if (busy_vec !== 16'h0080) begin
            n_fail++;
            $display("FAIL r0_claim: got %h exp 0080", busy_vec);
        end
        req0_valid = 1'b1; req0_reg = 4'h0; req0_data = 16'hFACE;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL r0_ready: got %b exp 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        n_checks++;
        if (rf_WriteReg !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_write: got %b exp 0", rf_WriteReg);
        end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_reg = 4'h9; req0_data = 16'h9999;
        claim_valid = 1'b1; claim_reg = 4'h9;
        rd_reg1 = 4'h9;
        step();
        req0_valid = 1'b0;
        claim_valid = 1'b0;
        n_checks++;
        if (rf_WriteReg !== 1'b1 || busy_vec !== 16'h0280) begin
            n_fail++;
            $display("FAIL mid_accept: got %b/%h exp 1/0280", rf_WriteReg, busy_vec);
        end
        rst = 1'b0;
        req1_valid = 1'b1; req1_reg = 4'h4;
        #1;
        n_checks++;
        if (req1_ready !== 1'b0 || rd_busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_comb: got %b/%b exp 0/0", req1_ready, rd_busy1);
        end
        step();
        n_checks++;
        if (rf_WriteReg !== 1'b0 || busy_vec !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_rst_state: got %b/%h exp 0/0000", rf_WriteReg, busy_vec);
        end
        req1_valid = 1'b0;
        rst = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
        req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
        claim_valid = 1'b0; claim_reg = '0;
        rd_reg1 = '0; rd_reg2 = '0;
        @(negedge clk);
        test_reset();
        test_lone();
        test_tie();
        test_back_to_back();
        test_scoreboard();
        test_r0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the RegisterFile's single write port (WriteReg/DstReg/DstData) between two writeback requesters: req0 = ALU writeback, req1 = memory-load writeback.
- Arbitrates between the requesters using a round-robin pointer.
- Registers the winning write into the RegisterFile port.
- Keeps a per-register pending-write scoreboard so decode can detect read-after-write hazards on SrcReg1/SrcReg2.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 4, register index width.
- NUM_REGS, 16, number of architectural registers (2**ADDR_W).
- ZERO_REG, 1, when 1 writes to register 0 are accepted but discarded and claims on register 0 are ignored.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-low. Sampled only at the rising edge of clk; rst=0 resets.
- req0_valid  input  1  ALU writeback request.
- req0_reg  input  ADDR_W  destination register for req0.
- req0_data  input  DATA_W  write data for req0.
- req0_ready  output  1  req0 accepted this cycle (combinational).
- req1_valid, req1_reg, req1_data, req1_ready: same as the req0 ports, for the load writeback.
- claim_valid  input  1  issue stage marks a register as pending.
- claim_reg  input  ADDR_W  register being claimed.
- rd_reg1  input  ADDR_W  decode source register 1.
- rd_reg2  input  ADDR_W  decode source register 2.
- rd_busy1  output  1  busy_vec[rd_reg1] (combinational).
- rd_busy2  output  1  busy_vec[rd_reg2] (combinational).
- busy_vec  output  NUM_REGS  scoreboard state (registered).
- rf_WriteReg  output  1  to RegisterFile WriteReg (registered).
- rf_DstReg  output  ADDR_W  to RegisterFile DstReg (registered).
- rf_DstData  output  DATA_W  to RegisterFile DstData (registered).

Behaviour:
- Reset (rst=0 at an edge):
  - rf_WriteReg=0, rf_DstReg=0, rf_DstData=0.
  - busy_vec=0.
  - Pointer state=PRI0.
  - While rst=0: req0_ready=req1_ready=0 and rd_busy1=rd_busy2=0.
  - Reset mid-operation discards any accepted-but-uncommitted write; no RF write occurs on the reset edge.
- Pointer FSM, two states:
  - PRI0: req0 wins a tie. PRI1: req1 wins a tie.
  - After a tie grant, the pointer moves to the other requester's priority state.
  - A single-requester grant sets the pointer to favour the other requester.
  - No grant: state holds.
- Arbitration (combinational):
  - Exactly one of req0_ready/req1_ready is high whenever any valid is high, else both are low.
  - A lone valid requester is granted immediately.
  - ready never depends on data or reg inputs.
- Transfer: reqX_valid & reqX_ready at an edge.
- Write stage, latency 1:
  - At the transfer edge: rf_WriteReg<=1, rf_DstReg<=reqX_reg, rf_DstData<=reqX_data.
  - The RegisterFile commits on the following edge.
  - No transfer: rf_WriteReg<=0 and rf_DstReg/rf_DstData hold.
  - ZERO_REG=1 with reqX_reg=0: the transfer is accepted (ready high) but rf_WriteReg<=0.
- Throughput: one write per cycle. The losing requester holds valid/reg/data stable until it sees ready.
- Scoreboard:
  - Set: claim_valid at an edge sets busy_vec[claim_reg]; ignored for reg 0 when ZERO_REG=1.
  - Clear: rf_WriteReg=1 at an edge clears busy_vec[rf_DstReg], i.e. the bit clears on the same edge the RF commits.
  - Set and clear of the same register on the same edge: set wins (busy stays 1).
  - Set and clear of different registers on the same edge: both apply.
  - A write to a non-busy register is legal and leaves the bit 0.
  - Re-claiming an already busy register keeps it 1. Single bit only, no counting.
- rd_busy1/rd_busy2 reflect busy_vec combinationally. There is no bypass of same-cycle claims or clears.

Test Plan:
- Reset: drive rst=0 for 2 edges with both valids high -> both readies 0, rf_WriteReg=0, busy_vec=16'h0000. Release rst=1 -> req0 granted first (PRI0).
- Lone request: req0_valid=1, reg=4'h1, data=16'h0001 -> req0_ready=1 the same cycle; after the next edge rf_WriteReg=1, rf_DstReg=1, rf_DstData=16'h0001; one edge later rf_WriteReg=0.
- Tie round-robin: both valid held 4 cycles, req0 reg=2/data=16'hAAAA, req1 reg=3/data=16'h5555 -> grants alternate 0,1,0,1; rf_DstReg sequence 2,3,2,3.
- Scoreboard: claim reg 5, then rd_reg1=5 -> rd_busy1=1 and busy_vec=16'h0020; req1 writes reg 5 -> busy_vec returns to 16'h0000 on the RF commit edge. A same-edge claim of reg 5 keeps the bit at 1.
- R0: claim reg 0 -> busy_vec unchanged. req0 write reg 0, data 16'hFACE -> req0_ready=1 but rf_WriteReg stays 0.
- Reset mid-write: transfer accepted, then rst=0 on the next edge -> rf_WriteReg=0 and busy_vec=0 after that edge; RegisterFile contents unchanged.
